// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the register-file write port, with an
// optional read bypass from queued entries (enabled by REGFILE_WB_BYPASS_EN).
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_data,
  input  logic        wb_hold,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic        empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [RW-1:0] dest;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_push;
  logic w_enq;
  logic w_pop;

  // Ready ignores a same-cycle pop, so a full queue stalls producers for a cycle.
  assign w_empty  = (r_count == '0);
  assign in_ready = (r_count < CW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_enq    = w_push && (in_dest != '0);
  assign w_pop    = wb_we;
  assign empty    = w_empty;

  assign wb_we   = !w_empty && !wb_hold;
  assign wb_addr = w_empty ? '0 : r_mem[r_rd_ptr].dest;
  assign wb_data = w_empty ? '0 : r_mem[r_rd_ptr].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; entries are only meaningful while covered by r_count.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= '{dest: in_dest, data: in_data};
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = rf_data1;
    fwd_data2 = rf_data2;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if ((rd_addr1 != '0) && (r_mem[AW'(r_rd_ptr + AW'(i))].dest == rd_addr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = r_mem[AW'(r_rd_ptr + AW'(i))].data;
        end
        if ((rd_addr2 != '0) && (r_mem[AW'(r_rd_ptr + AW'(i))].dest == rd_addr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = r_mem[AW'(r_rd_ptr + AW'(i))].data;
        end
      end
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{rd_addr1, rd_addr2};
  assign fwd_data1   = rf_data1;
  assign fwd_data2   = rf_data2;
  assign fwd_hit1    = 1'b0;
  assign fwd_hit2    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a falling-edge register-file model.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_dest;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rf_data1, rf_data2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        fwd_hit1, fwd_hit2;
  logic        empty;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rf_m [32];
  logic [36:0] wlog [$];
  logic [36:0] exp_q [$];

  regfile_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .wb_hold(wb_hold), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Register file captures on the falling edge.
  always @(negedge clk) begin
    if (wb_we === 1'b1) begin
      rf_m[wb_addr] = wb_data;
      wlog.push_back({wb_addr, wb_data});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [4:0]  d;
    logic [31:0] v;

    rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0; wb_hold = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; rf_data1 = 32'h0000_1234; rf_data2 = 32'h0000_5678;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_fwd_hit", {fwd_hit1, fwd_hit2}, 0);
    chk("rst_fwd_data1", fwd_data1, 32'h0000_1234);
    wlog.delete();

    // Single push, one-cycle retire
    in_valid = 1'b1; in_dest = 5'd5; in_data = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    #1;
    chk("single_we", wb_we, 1);
    chk("single_addr", wb_addr, 5);
    chk("single_data", wb_data, 32'hDEAD_BEEF);
    chk("single_empty", empty, 0);
    step();
    chk("single_after_we", wb_we, 0);
    chk("single_after_empty", empty, 1);
    chk("single_rf5", rf_m[5], 32'hDEAD_BEEF);
    chk("single_wcount", wlog.size(), 1);

    // Fill under hold; fifth push refused even as hold releases
    wb_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_dest = 5'(k); in_data = 32'(k * 'h11);
      step();
      if (k == 3) chk("fill_ready_at3", in_ready, 1);
    end
    in_dest = 5'd5; in_data = 32'h55; wb_hold = 1'b0;
    #1;
    chk("full_ready", in_ready, 0);
    chk("full_we", wb_we, 1);
    chk("full_head", {wb_addr, wb_data}, {5'd1, 32'h11});
    base = wlog.size();
    for (int k = 2; k <= 4; k++) begin
      step();
      in_valid = 1'b0;
      #1;
      chk("drain_head", {wb_addr, wb_data}, {5'(k), 32'(k * 'h11)});
    end
    step();
    chk("drain_empty", empty, 1);
    chk("drain_wcount", wlog.size() - base, 4);
    for (int k = 1; k <= 4; k++)
      chk("drain_order", wlog[base + k - 1], {5'(k), 32'(k * 'h11)});

    // Destination 0 is accepted but discarded
    in_valid = 1'b1; in_dest = 5'd0; in_data = 32'hFFFF_FFFF;
    #1;
    chk("zero_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    chk("zero_empty", empty, 1);
    chk("zero_we", wb_we, 0);
    base = wlog.size();
    step();
    chk("zero_no_write", wlog.size(), base);

    // Bypass: youngest same-dest entry wins, address 0 never hits
    wb_hold = 1'b1;
    in_valid = 1'b1; in_dest = 5'd7; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_valid = 1'b0;
    rd_addr1 = 5'd7; rd_addr2 = 5'd0;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_data1", fwd_data1, 32'hB);
    chk("byp_hit1", fwd_hit1, 1);
`else
    chk("byp_data1", fwd_data1, 32'h0000_1234);
    chk("byp_hit1", fwd_hit1, 0);
`endif
    chk("byp_hit2", fwd_hit2, 0);
    chk("byp_data2", fwd_data2, 32'h0000_5678);

    // Third entry, then a reset discards everything pending
    in_valid = 1'b1; in_dest = 5'd9; in_data = 32'hC;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; wb_hold = 1'b0;
    #1;
    chk("mrst_empty", empty, 1);
    chk("mrst_we", wb_we, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_hit1", fwd_hit1, 0);
    step(); step();
    chk("mrst_no_write", wlog.size(), base);
    rd_addr1 = '0;

    // Streaming push/pop every cycle
    wlog.delete();
    for (int i = 0; i < 20; i++) begin
      d = 5'($urandom_range(31, 1));
      v = $urandom;
      in_valid = 1'b1; in_dest = d; in_data = v;
      exp_q.push_back({d, v});
      step();
      chk("stream_head", {in_ready, wb_we, wb_addr, wb_data}, {1'b1, 1'b1, d, v});
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", empty, 1);
    chk("stream_wcount", wlog.size(), 20);
    for (int i = 0; i < 20 && i < wlog.size(); i++)
      chk("stream_order", wlog[i], exp_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
